// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has absolute priority, MDU results queue in a 2-entry in-order FIFO.
// Optional starvation stall request is built only when RF_ARB_STARVE_EN is defined.
module rf_write_arbiter #(
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_waddr,
   input  logic [63:0] pipe_wdata,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_waddr,
   input  logic [63:0] mdu_wdata,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [63:0] rf_wdata,
   output logic        stall_req,
   output logic [1:0]  pend_cnt
);

   typedef struct packed {
      logic [4:0]  addr;
      logic [63:0] data;
   } ent_t;

   ent_t        fifo_q [2];
   ent_t        fifo_d [2];
   logic [1:0]  cnt_q, cnt_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_waddr_q, rf_waddr_d;
   logic [63:0] rf_wdata_q, rf_wdata_d;

   logic        pipe_v;
   logic        accept;
   logic        enq;
   logic        pop;
   logic        inval;
   logic [1:0]  keep;
   ent_t        lst [2];
   ent_t        new_ent;
   logic [1:0]  surv_n;
   logic [1:0]  tot;

   // mdu_ready only looks at registered occupancy, so a full FIFO never accepts even if it pops this cycle.
   assign mdu_ready = !rst && (cnt_q != 2'd2);

   always_comb begin
      pipe_v  = pipe_we && (pipe_waddr != 5'd0);
      accept  = mdu_valid && mdu_ready;
      new_ent = '{addr: mdu_waddr, data: mdu_wdata};

      // Pipeline write is younger than anything buffered: matching entries die without writing.
      keep[0] = (cnt_q >= 2'd1) && !(pipe_v && (fifo_q[0].addr == pipe_waddr));
      keep[1] = (cnt_q == 2'd2) && !(pipe_v && (fifo_q[1].addr == pipe_waddr));
      inval   = ((cnt_q >= 2'd1) && !keep[0]) || ((cnt_q == 2'd2) && !keep[1]);

      lst[0] = fifo_q[0];
      lst[1] = fifo_q[1];
      surv_n = 2'd0;
      if (keep[0] && keep[1]) begin
         surv_n = 2'd2;
      end else if (keep[0]) begin
         surv_n = 2'd1;
      end else if (keep[1]) begin
         lst[0] = fifo_q[1];
         surv_n = 2'd1;
      end

      enq = accept && (mdu_waddr != 5'd0) && !(pipe_v && (mdu_waddr == pipe_waddr));
      if (enq) begin
         if (surv_n == 2'd0) begin
            lst[0] = new_ent;
         end else begin
            lst[1] = new_ent;
         end
      end
      tot = surv_n + {1'b0, enq};

      // Popping after the append gives the empty-FIFO bypass for free.
      pop = !pipe_v && (tot != 2'd0);

      fifo_d[0] = lst[0];
      fifo_d[1] = lst[1];
      cnt_d     = tot;
      if (pop) begin
         fifo_d[0] = lst[1];
         cnt_d     = tot - 2'd1;
      end

      rf_we_d    = 1'b0;
      rf_waddr_d = 5'd0;
      rf_wdata_d = 64'd0;
      if (pipe_v) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = pipe_waddr;
         rf_wdata_d = pipe_wdata;
      end else if (pop) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = lst[0].addr;
         rf_wdata_d = lst[0].data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         cnt_q      <= 2'd0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= 5'd0;
         rf_wdata_q <= 64'd0;
      end else begin
         fifo_q[0]  <= fifo_d[0];
         fifo_q[1]  <= fifo_d[1];
         cnt_q      <= cnt_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign pend_cnt = cnt_q;

`ifdef RF_ARB_STARVE_EN
   localparam int SCW = $clog2(STARVE_MAX + 1);

   logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
   logic           stall_q, stall_d;

   // Counts consecutive cycles where something is buffered but nothing leaves; saturates at STARVE_MAX.
   always_comb begin
      starve_cnt_d = '0;
      if (!(pop || inval) && (cnt_q != 2'd0)) begin
         if (starve_cnt_q >= SCW'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q;
         end else begin
            starve_cnt_d = starve_cnt_q + SCW'(1);
         end
      end
      stall_d = (starve_cnt_d >= SCW'(STARVE_MAX));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
         stall_q      <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         stall_q      <= stall_d;
      end
   end

   assign stall_req = stall_q;
`else
   assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_rf_write_arbiter;

   localparam int SMAX = 8;

   logic        clk;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_waddr;
   logic [63:0] pipe_wdata;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_waddr;
   logic [63:0] mdu_wdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        stall_req;
   logic [1:0]  pend_cnt;

   rf_write_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk        (clk),
      .rst        (rst),
      .pipe_we    (pipe_we),
      .pipe_waddr (pipe_waddr),
      .pipe_wdata (pipe_wdata),
      .mdu_valid  (mdu_valid),
      .mdu_ready  (mdu_ready),
      .mdu_waddr  (mdu_waddr),
      .mdu_wdata  (mdu_wdata),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .stall_req  (stall_req),
      .pend_cnt   (pend_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state: buffered {addr, data} in arrival order
   logic [68:0] exp_q[$];
   int          starve = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, check mdu_ready, advance the model, check registered outputs.
   task automatic step(input logic r, input logic pwe, input logic [4:0] pa, input logic [63:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [63:0] md);
      logic        pv, acc, inval, popped, nonempty, ew, es;
      logic [4:0]  ea;
      logic [63:0] ed;
      logic [68:0] e;
      rst = r; pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
      mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
      #1;
      check_eq("mdu_ready", {63'd0, mdu_ready}, {63'd0, (!r && exp_q.size() < 2)});
      ew = 1'b0; ea = 5'd0; ed = 64'd0; es = 1'b0;
      if (r) begin
         exp_q.delete();
         starve = 0;
      end else begin
         pv       = pwe && (pa != 5'd0);
         acc      = mv && (exp_q.size() < 2);
         nonempty = (exp_q.size() != 0);
         inval    = 1'b0;
         popped   = 1'b0;
         if (pv) begin
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
               if (exp_q[i][68:64] == pa) begin
                  exp_q.delete(i);
                  inval = 1'b1;
               end
            end
         end
         if (acc && (ma != 5'd0) && !(pv && (ma == pa))) exp_q.push_back({ma, md});
         if (pv) begin
            ew = 1'b1; ea = pa; ed = pd;
         end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ew = 1'b1; ea = e[68:64]; ed = e[63:0];
            popped = 1'b1;
         end
`ifdef RF_ARB_STARVE_EN
         if (popped || inval) starve = 0;
         else if (nonempty) starve++;
         else starve = 0;
         es = (starve >= SMAX);
`else
         es = 1'b0;
`endif
      end
      @(posedge clk);
      #1;
      check_eq("rf_we", {63'd0, rf_we}, {63'd0, ew});
      check_eq("rf_waddr", {59'd0, rf_waddr}, {59'd0, ea});
      check_eq("rf_wdata", rf_wdata, ed);
      check_eq("pend_cnt", {62'd0, pend_cnt}, 64'(exp_q.size()));
      check_eq("stall_req", {63'd0, stall_req}, {63'd0, es});
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
   endtask

   initial begin
      rst = 1'b1; pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 64'd0;
      mdu_valid = 1'b0; mdu_waddr = 5'd0; mdu_wdata = 64'd0;
      @(posedge clk); #1;

      // reset state, then first cycle out of reset must be ready
      step(1'b1, 1'b1, 5'd4, 64'h1, 1'b1, 5'd6, 64'h2);
      step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      #1 check_eq("ready_in_rst", {63'd0, mdu_ready}, 64'd0);
      rst = 1'b0;
      #1 check_eq("ready_after_rst", {63'd0, mdu_ready}, 64'd1);
      @(posedge clk); #1;

      // simple pipeline write
      step(1'b0, 1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0);
      check_eq("pipe_addr", {59'd0, rf_waddr}, 64'd5);
      check_eq("pipe_data", rf_wdata, 64'hAA);

      // MDU push alongside pipeline write
      step(1'b0, 1'b1, 5'd3, 64'h33, 1'b1, 5'd7, 64'h11);
      check_eq("t1_addr", {59'd0, rf_waddr}, 64'd3);
      check_eq("t1_pend", {62'd0, pend_cnt}, 64'd1);
      idle();
      check_eq("t2_addr", {59'd0, rf_waddr}, 64'd7);
      check_eq("t2_data", rf_wdata, 64'h11);

      // fill, refuse third, drain in order
      step(1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd10, 64'hA0);
      step(1'b0, 1'b1, 5'd2, 64'h2, 1'b1, 5'd11, 64'hB0);
      check_eq("full_pend", {62'd0, pend_cnt}, 64'd2);
      step(1'b0, 1'b1, 5'd4, 64'h4, 1'b1, 5'd12, 64'hC0);
      check_eq("full_hold", {62'd0, pend_cnt}, 64'd2);
      idle();
      check_eq("drain0", {59'd0, rf_waddr}, 64'd10);
      idle();
      check_eq("drain1", {59'd0, rf_waddr}, 64'd11);
      check_eq("drained", {62'd0, pend_cnt}, 64'd0);

      // invalidation by a younger pipeline write
      step(1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd9, 64'h99);
      step(1'b0, 1'b1, 5'd9, 64'h55, 1'b0, 5'd0, 64'd0);
      check_eq("inv_data", rf_wdata, 64'h55);
      check_eq("inv_pend", {62'd0, pend_cnt}, 64'd0);
      idle();
      check_eq("inv_nowr", {63'd0, rf_we}, 64'd0);

      // same-cycle collision discards the MDU result
      step(1'b0, 1'b1, 5'd8, 64'h8, 1'b1, 5'd8, 64'hDEAD);
      idle();
      check_eq("coll_nowr", {63'd0, rf_we}, 64'd0);

      // x0 MDU result is swallowed
      step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h77);
      check_eq("x0_pend", {62'd0, pend_cnt}, 64'd0);
      check_eq("x0_we", {63'd0, rf_we}, 64'd0);

      // bypass into an empty FIFO
      step(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd13, 64'hBEEF);
      check_eq("byp_addr", {59'd0, rf_waddr}, 64'd13);

      // starvation: one entry buffered, pipeline busy for 10 cycles
      step(1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd20, 64'h20);
      for (int k = 1; k <= 10; k++) begin
         step(1'b0, 1'b1, 5'(k % 4 + 1), 64'(k), 1'b0, 5'd0, 64'd0);
`ifdef RF_ARB_STARVE_EN
         if (k == SMAX - 1) check_eq("starve_lo", {63'd0, stall_req}, 64'd0);
         if (k == SMAX) check_eq("starve_hi", {63'd0, stall_req}, 64'd1);
`endif
      end
      idle();
      check_eq("starve_pop", {59'd0, rf_waddr}, 64'd20);
      check_eq("starve_clr", {63'd0, stall_req}, 64'd0);

      // reset mid-operation drops buffered entries
      step(1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd14, 64'h14);
      step(1'b0, 1'b1, 5'd2, 64'h2, 1'b1, 5'd15, 64'h15);
      step(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
      idle();
      check_eq("rst_drop", {63'd0, rf_we}, 64'd0);

      // random traffic on a small address range to force collisions
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), {$urandom, $urandom},
              ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), {$urandom, $urandom});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- pipe_we  in  1  pipeline writeback write request.
- pipe_waddr  in  5  pipeline destination register.
- pipe_wdata  in  64  pipeline write data.
- mdu_valid  in  1  multi-cycle unit result valid.
- mdu_ready  out  1  arbiter can accept an MDU result.
- mdu_waddr  in  5  MDU destination register.
- mdu_wdata  in  64  MDU result data.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  5  register-file write address, registered.
- rf_wdata  out  64  register-file write data, registered.
- stall_req  out  1  request to the pipeline to insert one writeback bubble.
- pend_cnt  out  2  number of buffered MDU results (0..2).
REQ-002 SHALL have one parameter: STARVE_MAX, default 8, the number of consecutive cycles without a pop before starvation is declared.

Function
REQ-003 SHALL buffer MDU results in a 2-entry in-order FIFO; the MDU handshake completes on any cycle where mdu_valid and mdu_ready are both 1.
REQ-004 SHALL drive mdu_ready = !full, using the registered occupancy; a pop and a push in the same cycle while full SHALL NOT be accepted.
REQ-005 SHALL give the pipeline absolute priority: if pipe_we=1 and pipe_waddr!=0, the pipeline write is presented on the rf_* outputs one cycle later.
REQ-006 SHALL pop the FIFO head onto the rf_* outputs, again one cycle later, in any cycle where no valid pipeline write exists and the FIFO is non-empty.
REQ-007 SHALL register rf_we=0, rf_waddr=0 and rf_wdata=0 in any cycle where neither source writes.
REQ-008 SHALL never issue a write to x0:
- a pipeline write with waddr=0 is treated as no write;
- an MDU result with waddr=0 completes the handshake but is discarded, not enqueued.
REQ-009 SHALL treat a pipeline write as younger than every buffered entry: a buffered entry whose waddr equals the valid pipe_waddr SHALL be invalidated that cycle and removed without writing.
REQ-010 SHALL discard an MDU result accepted in the same cycle as a valid pipeline write to the same address; the handshake still completes.
REQ-011 SHALL compact the FIFO when an entry is invalidated, preserving the order of the surviving entries, and update pend_cnt in the following cycle.
REQ-012 SHALL make pend_cnt equal the registered FIFO occupancy; it SHALL never exceed 2.
REQ-013 SHALL make the latency from a pipeline request, or a FIFO pop decision, to rf_we exactly 1 cycle.
REQ-014 SHALL accept and pop in the same cycle when the FIFO is empty and mdu_valid=1 and pipe_we=0, so the MDU result appears on the rf_* outputs after 1 cycle (bypass).

Reset
REQ-015 SHALL, while rst=1, clear the FIFO and the starvation counter and hold rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, pend_cnt=0 and mdu_ready=0.
REQ-016 SHALL drive mdu_ready=1 in the first cycle after rst falls.
REQ-017 SHALL discard all buffered entries when rst is asserted mid-operation, with no write issued for them.

Configuration
REQ-018 SHALL, when RF_ARB_STARVE_EN is defined:
- count consecutive cycles in which the FIFO is non-empty and no pop occurs;
- register stall_req=1 when the count reaches STARVE_MAX;
- clear the counter and stall_req on the cycle after any pop or invalidation.
REQ-019 SHALL, when RF_ARB_STARVE_EN is undefined, tie stall_req to 0 and contain no starvation counter.

Verification
REQ-020 SHALL be verified by pipe_we=1, waddr=5, wdata=0xAA, with the MDU idle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAA.
REQ-021 SHALL be verified by an MDU push (waddr=7, data=0x11) in the same cycle as pipe_we=1 (waddr=3) -> pipe write to x3 at t+1, MDU write to x7 at t+2, pend_cnt=1 at t+1.
REQ-022 SHALL be verified by two MDU pushes while pipe_we is held at 1 -> pend_cnt=2, mdu_ready=0, third mdu_valid not accepted; releasing pipe_we -> both entries drained in order over 2 cycles.
REQ-023 SHALL be verified by buffering an MDU entry with waddr=9, then pipe_we to x9 -> the entry is invalidated, pend_cnt=0, and only the pipeline value is written to x9.
REQ-024 SHALL be verified, with RF_ARB_STARVE_EN defined and STARVE_MAX=8, by holding pipe_we=1 for 10 cycles with 1 buffered entry -> stall_req=1 after 8 cycles, clearing on the cycle after the pop.
REQ-025 SHALL be verified by an MDU push with waddr=0 -> handshake completes, pend_cnt stays 0, rf_we stays 0.
